// File: rtl/bus_arbiter.sv
// Bus arbiter: shares one downstream memory bus between the instruction-fetch
// port (read-only) and the memory-stage data port. Only one transaction is in
// flight at a time. The data port normally wins. A starvation counter forces a
// waiting fetch through after STARVE_LIMIT consecutive data grants.
module bus_arbiter #(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   // fetch port
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic [DATA_W-1:0]   i_rdata,
   // data port
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [2:0]          d_size,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   // downstream bus
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [2:0]          m_size,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_ready,
   input  logic [DATA_W-1:0]   m_rdata,
   // status
   output logic                busy
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   // Fetches are always full-word reads.
   localparam logic [2:0] FETCH_SIZE = 3'b010;

   typedef enum logic [1:0] {
      StIdle,
      StGrantI,
      StGrantD
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;

   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [STRB_W-1:0] strobe_q;
   logic [DATA_W-1:0] wdata_q;

   logic              fetch_forced;
   logic              take_d;
   logic              take_i;

   // A waiting fetch that has been passed over STARVE_LIMIT times beats data.
   assign fetch_forced = i_valid && (starve_q == STARVE_MAX);

   // Next-state, grant decision and starvation bookkeeping.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      take_d   = 1'b0;
      take_i   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (d_valid && !fetch_forced) begin
               state_d = StGrantD;
               take_d  = 1'b1;
               // Only count data grants that made a fetch wait; saturate.
               if (i_valid && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + CNT_W'(1);
               end
            end else if (i_valid) begin
               state_d  = StGrantI;
               take_i   = 1'b1;
               starve_d = '0;
            end
         end
         StGrantI, StGrantD: begin
            if (m_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and starvation counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Downstream request fields: captured once at grant, frozen for the grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         wdata_q  <= '0;
      end else if (take_d) begin
         addr_q   <= d_addr;
         size_q   <= d_size;
         strobe_q <= d_strobe;
         wdata_q  <= d_wdata;
      end else if (take_i) begin
         addr_q   <= i_addr;
         size_q   <= FETCH_SIZE;
         strobe_q <= '0;
         wdata_q  <= '0;
      end
   end

   // Outputs decode directly from state so reset drops m_valid asynchronously.
   always_comb begin
      m_valid  = (state_q != StIdle);
      busy     = (state_q != StIdle);
      m_addr   = addr_q;
      m_size   = size_q;
      m_strobe = strobe_q;
      m_wdata  = wdata_q;
      i_ready  = (state_q == StGrantI) && m_ready;
      d_ready  = (state_q == StGrantD) && m_ready;
      i_rdata  = i_ready ? m_rdata : '0;
      d_rdata  = d_ready ? m_rdata : '0;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: random requesters and a random downstream
// responder, with a transaction-level arbitration model feeding a scoreboard.
module tb_bus_arbiter;

   localparam int unsigned ADDR_W       = 64;
   localparam int unsigned DATA_W       = 64;
   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned STRB_W       = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_valid, i_ready, d_valid, d_ready, m_valid, m_ready, busy;
   logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
   logic [DATA_W-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
   logic [2:0]        d_size, m_size;
   logic [STRB_W-1:0] d_strobe, m_strobe;

   bus_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_rdata (i_rdata),
      .d_valid (d_valid),
      .d_addr  (d_addr),
      .d_size  (d_size),
      .d_strobe(d_strobe),
      .d_wdata (d_wdata),
      .d_ready (d_ready),
      .d_rdata (d_rdata),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_size  (m_size),
      .m_strobe(m_strobe),
      .m_wdata (m_wdata),
      .m_ready (m_ready),
      .m_rdata (m_rdata),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                fetch;
      logic [ADDR_W-1:0] addr;
      logic [2:0]        size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] wdata;
   } txn_t;

   txn_t exp_q[$];
   bit   grant_log[$];  // 1 = fetch, in completion order
   int   tests = 0;
   int   fails = 0;

   // Reference model state: who owns the bus (0 none, 1 fetch, 2 data) and how
   // many data grants a waiting fetch has been passed over.
   int   owner = 0;
   int   waits = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: decides grants from the arbitration rules and pushes expectations.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            owner = 0;
            waits = 0;
            exp_q.delete();
         end else begin
            check("m_valid", 64'(m_valid), 64'(owner != 0));
            check("busy", 64'(busy), 64'(owner != 0));
            if (owner != 0) begin
               if (m_ready) owner = 0;
            end else if (d_valid && !(i_valid && waits == STARVE_LIMIT)) begin
               exp_q.push_back('{1'b0, d_addr, d_size, d_strobe, d_wdata});
               owner = 2;
               if (i_valid && waits < STARVE_LIMIT) waits++;
            end else if (i_valid) begin
               exp_q.push_back('{1'b1, i_addr, 3'b010, '0, '0});
               owner = 1;
               waits = 0;
            end
         end
      end
   end

   // Monitor: compares what the DUT presents against the scoreboard front.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (m_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_grant: got m_valid=1, required no transaction (t=%0t)",
                           $time);
               end else begin
                  t = exp_q[0];
                  check("m_addr", m_addr, t.addr);
                  check("m_size", 64'(m_size), 64'(t.size));
                  check("m_strobe", 64'(m_strobe), 64'(t.strobe));
                  check("m_wdata", m_wdata, t.wdata);
                  if (m_ready) begin
                     check("i_ready", 64'(i_ready), 64'(t.fetch));
                     check("d_ready", 64'(d_ready), 64'(!t.fetch));
                     if (t.fetch) check("i_rdata", i_rdata, m_rdata);
                     else         check("d_rdata", d_rdata, m_rdata);
                     t = exp_q.pop_front();
                     grant_log.push_back(t.fetch);
                  end else begin
                     check("ready_while_waiting", 64'({i_ready, d_ready}), 64'(0));
                  end
               end
            end else begin
               check("ready_while_idle", 64'({i_ready, d_ready}), 64'(0));
            end
         end
      end
   end

   bit i_done, d_done;

   task automatic randomize_fields();
      i_addr   = {32'h8000_0000, $urandom};
      d_addr   = {$urandom, $urandom};
      d_size   = 3'($urandom_range(0, 7));
      d_strobe = STRB_W'($urandom);
      d_wdata  = {$urandom, $urandom};
      m_rdata  = {$urandom, $urandom};
   endtask

   // One cycle of random traffic; fields keep changing so frozen m_* is tested.
   task automatic random_cycle();
      @(negedge clk);
      i_done = i_ready;
      d_done = d_ready;
      @(posedge clk);
      #1;
      if (i_done) i_valid = 1'b0;
      else if (i_valid && $urandom_range(0, 63) == 0) i_valid = 1'b0;
      if (!i_valid && $urandom_range(0, 3) == 0) i_valid = 1'b1;
      if (d_done) d_valid = 1'b0;
      else if (d_valid && $urandom_range(0, 63) == 0) d_valid = 1'b0;
      if (!d_valid && $urandom_range(0, 2) == 0) d_valid = 1'b1;
      m_ready = ($urandom_range(0, 2) == 0);
      randomize_fields();
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      d_valid = 1'b0;
      m_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      bit got;
      i_valid = 1'b0;
      d_valid = 1'b0;
      m_ready = 1'b1;
      randomize_fields();
      m_rdata = '1;

      // Reset state, with m_ready high to show readies stay gated.
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ready", 64'({i_ready, d_ready}), 64'(0));
      check("rst_m_addr", m_addr, 64'(0));
      check("rst_m_size", 64'(m_size), 64'(0));
      check("rst_m_strobe", 64'(m_strobe), 64'(0));
      check("rst_m_wdata", m_wdata, 64'(0));
      check("rst_i_rdata", i_rdata, 64'(0));
      check("rst_d_rdata", d_rdata, 64'(0));
      @(posedge clk);
      #2;
      rst = 1'b1;

      for (int c = 0; c < 3000; c++) random_cycle();
      drain();

      // Reset in the middle of a fetch grant.
      i_valid = 1'b1;
      m_ready = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = m_valid;
      end
      check("reach_grant_i", 64'(got), 64'(1));
      #3;
      rst = 1'b0;
      #1;
      check("midrst_m_valid", 64'(m_valid), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_i_ready", 64'(i_ready), 64'(0));
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;

      // Both ports hold requests and the bus answers at once: after a reset the
      // order must be D,D,D,D,I repeating.
      grant_log.delete();
      i_valid = 1'b1;
      d_valid = 1'b1;
      m_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         randomize_fields();
      end
      check("starve_grants", 64'(grant_log.size() >= 15), 64'(1));
      for (int k = 0; k < 15 && k < grant_log.size(); k++) begin
         check($sformatf("starve_order_%0d", k), 64'(grant_log[k]), 64'(k % 5 == 4));
      end
      drain();

      for (int c = 0; c < 1500; c++) random_cycle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
